// File: rtl/dpu_core.sv
// dpu_core: 16x8 register-file datapath with flag ALU and registered pixel port.
// Define DPU_AUTO_OUT_EN to reload Kbus on every edge and ignore outEnable.
module dpu_core (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  Abus,
  input  logic [3:0]  Bbus,
  input  logic [3:0]  Rbus,
  input  logic [3:0]  n,
  input  logic [7:0]  mData,
  input  logic        outEnable,
  output logic [3:0]  cc,
  output logic [23:0] Kbus
);

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,
    OP_SUB  = 4'd1,
    OP_SHL  = 4'd2,
    OP_SHR  = 4'd3,
    OP_AND  = 4'd4,
    OP_OR   = 4'd5,
    OP_CMP  = 4'd6,
    OP_MOV  = 4'd7,
    OP_LOAD = 4'd8
  } op_e;

  localparam logic [3:0] R_ONE  = 4'd12;
  localparam logic [3:0] R_ZERO = 4'd13;

  logic [7:0]  regs_q [16];
  logic [3:0]  cc_q, cc_d;
  logic [23:0] kbus_q, kbus_d;

  logic [7:0]  a, b;
  logic [7:0]  res;
  logic        wr_en, cc_en;
  logic        c_flag, v_flag;
  logic [8:0]  sum9, dif9;

  function automatic logic [7:0] rd(input logic [3:0] idx,
                                    input logic [7:0] val);
    if (idx == R_ONE)       rd = 8'h01;
    else if (idx == R_ZERO) rd = 8'h00;
    else                    rd = val;
  endfunction

  assign a = rd(Abus, regs_q[Abus]);
  assign b = rd(Bbus, regs_q[Bbus]);

  assign sum9 = {1'b0, a} + {1'b0, b};
  assign dif9 = {1'b0, a} - {1'b0, b};

  always_comb begin
    res    = 8'h00;
    wr_en  = 1'b0;
    cc_en  = 1'b0;
    c_flag = 1'b0;
    v_flag = 1'b0;
    unique case (n)
      OP_ADD: begin
        res    = sum9[7:0];
        c_flag = sum9[8];
        v_flag = (a[7] == b[7]) && (res[7] != a[7]);
        wr_en  = 1'b1;
        cc_en  = 1'b1;
      end
      OP_SUB, OP_CMP: begin
        res    = dif9[7:0];
        // C is the inverted borrow
        c_flag = ~dif9[8];
        v_flag = (a[7] != b[7]) && (res[7] != a[7]);
        wr_en  = (n == OP_SUB);
        cc_en  = 1'b1;
      end
      OP_SHL: begin
        res    = {a[6:0], 1'b0};
        c_flag = a[7];
        wr_en  = 1'b1;
        cc_en  = 1'b1;
      end
      OP_SHR: begin
        res    = {a[7], a[7:1]};
        c_flag = a[0];
        wr_en  = 1'b1;
        cc_en  = 1'b1;
      end
      OP_AND: begin
        res   = a & b;
        wr_en = 1'b1;
        cc_en = 1'b1;
      end
      OP_OR: begin
        res   = a | b;
        wr_en = 1'b1;
        cc_en = 1'b1;
      end
      OP_MOV: begin
        res   = a;
        wr_en = 1'b1;
        cc_en = 1'b1;
      end
      OP_LOAD: begin
        res   = mData;
        wr_en = 1'b1;
      end
      default: begin
        res = 8'h00;
      end
    endcase
  end

  always_comb begin
    cc_d = cc_q;
    if (cc_en) cc_d = {res[7], (res == 8'h00), c_flag, v_flag};
  end

  always_comb begin
    kbus_d = kbus_q;
`ifdef DPU_AUTO_OUT_EN
    kbus_d = {regs_q[9], regs_q[10], regs_q[11]};
`else
    if (outEnable) kbus_d = {regs_q[9], regs_q[10], regs_q[11]};
`endif
  end

`ifdef DPU_AUTO_OUT_EN
  logic unused_oe;
  assign unused_oe = outEnable;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs_q[i] <= 8'h00;
    end else if (wr_en && Rbus != R_ONE && Rbus != R_ZERO) begin
      regs_q[Rbus] <= res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cc_q   <= 4'b0000;
      kbus_q <= 24'h0;
    end else begin
      cc_q   <= cc_d;
      kbus_q <= kbus_d;
    end
  end

  assign cc   = cc_q;
  assign Kbus = kbus_q;

endmodule

// File: tb/tb_dpu_core.sv
// tb_dpu_core: directed vectors for dpu_core, registers observed via MOV to R11
// and the Kbus strobe; expects DPU_AUTO_OUT_EN undefined.
module tb_dpu_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  Abus, Bbus, Rbus, n;
  logic [7:0]  mData;
  logic        outEnable;
  logic [3:0]  cc;
  logic [23:0] Kbus;

  int checks = 0;
  int errors = 0;

  dpu_core dut (
    .clk(clk), .rst_n(rst_n), .Abus(Abus), .Bbus(Bbus), .Rbus(Rbus),
    .n(n), .mData(mData), .outEnable(outEnable), .cc(cc), .Kbus(Kbus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [3:0] nn, input logic [3:0] a,
                    input logic [3:0] b, input logic [3:0] r,
                    input logic [7:0] md, input logic oe);
    @(negedge clk);
    n = nn; Abus = a; Bbus = b; Rbus = r; mData = md; outEnable = oe;
    @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [3:0] r, input logic [7:0] md);
    op(4'd8, 4'd0, 4'd0, r, md, 1'b0);
  endtask

  task automatic strobe();
    op(4'd9, 4'd0, 4'd0, 4'd0, 8'h00, 1'b1);
  endtask

  task automatic peek(input logic [3:0] r);
    op(4'd7, r, 4'd0, 4'd11, 8'h00, 1'b0);
    strobe();
  endtask

  initial begin
    rst_n = 1'b0; Abus = 0; Bbus = 0; Rbus = 0; n = 4'd9;
    mData = 0; outEnable = 0;
    #12 rst_n = 1'b1;

    // async reset mid-cycle
    ld(4'd9, 8'h12);
    op(4'd0, 4'd9, 4'd12, 4'd10, 8'h00, 1'b0);
    strobe();
    check("pre_rst_kbus", Kbus, 24'h121300);
    #2 rst_n = 1'b0;
    #1;
    check("rst_kbus", Kbus, 24'h0);
    check("rst_cc", cc, 4'b0000);
    @(negedge clk) rst_n = 1'b1;
    peek(4'd9);
    check("rst_regs", Kbus, 24'h0);

    // LOAD / ADD
    ld(4'd9, 8'h10);
    op(4'd0, 4'd9, 4'd12, 4'd9, 8'h00, 1'b0);
    check("add_cc", cc, 4'b0000);
    strobe();
    check("add_res", Kbus, 24'h110000);
    ld(4'd9, 8'hFF);
    op(4'd0, 4'd9, 4'd12, 4'd9, 8'h00, 1'b0);
    check("add_wrap_cc", cc, 4'b0110);
    ld(4'd15, 8'h7F);
    op(4'd0, 4'd15, 4'd12, 4'd15, 8'h00, 1'b0);
    check("add_ovf_cc", cc, 4'b1001);
    op(4'd1, 4'd15, 4'd12, 4'd15, 8'h00, 1'b0);
    check("sub_ovf_cc", cc, 4'b0011);

    // SUB / CMP
    ld(4'd8, 8'd20);
    ld(4'd7, 8'd5);
    op(4'd1, 4'd8, 4'd7, 4'd1, 8'h00, 1'b0);
    check("sub_cc", cc, 4'b0010);
    peek(4'd1);
    check("sub_res", Kbus[7:0], 8'd15);
    ld(4'd14, 8'h33);
    ld(4'd2, 8'hF6);
    op(4'd6, 4'd2, 4'd13, 4'd14, 8'h00, 1'b0);
    check("cmp_cc", cc, 4'b1010);
    peek(4'd14);
    check("cmp_nowr", Kbus[7:0], 8'h33);

    // shifts
    ld(4'd1, 8'h0F);
    op(4'd2, 4'd1, 4'd0, 4'd4, 8'h00, 1'b0);
    check("shl_cc", cc, 4'b0000);
    peek(4'd4);
    check("shl_res", Kbus[7:0], 8'h1E);
    ld(4'd1, 8'h80);
    op(4'd2, 4'd1, 4'd0, 4'd4, 8'h00, 1'b0);
    check("shl_out_cc", cc, 4'b0110);
    ld(4'd1, 8'h81);
    op(4'd3, 4'd1, 4'd0, 4'd4, 8'h00, 1'b0);
    check("shr_cc", cc, 4'b1010);
    peek(4'd4);
    check("shr_res", Kbus[7:0], 8'hC0);

    // AND / OR, flags held by NOP and LOAD
    ld(4'd5, 8'hF0);
    ld(4'd6, 8'h3C);
    op(4'd4, 4'd5, 4'd6, 4'd11, 8'h00, 1'b0);
    check("and_cc", cc, 4'b0000);
    op(4'd5, 4'd5, 4'd6, 4'd10, 8'h00, 1'b0);
    check("or_cc", cc, 4'b1000);
    strobe();
    check("andor_res", Kbus[15:0], 16'hFC30);
    op(4'd15, 4'd0, 4'd0, 4'd0, 8'h00, 1'b0);
    check("nop_cc", cc, 4'b1000);
    ld(4'd15, 8'h00);
    check("load_cc", cc, 4'b1000);

    // pixel output
    ld(4'd9, 8'h03);
    ld(4'd10, 8'h07);
    ld(4'd11, 8'hAA);
    strobe();
    check("kbus_load", Kbus, 24'h0307AA);
    ld(4'd9, 8'h44);
    check("kbus_hold", Kbus, 24'h0307AA);
    op(4'd8, 4'd0, 4'd0, 4'd9, 8'h55, 1'b1);
    check("kbus_prewr", Kbus, 24'h4407AA);
    strobe();
    check("kbus_new", Kbus, 24'h5507AA);
    op(4'd0, 4'd9, 4'd9, 4'd9, 8'h00, 1'b0);
    strobe();
    check("alias_add", Kbus, 24'hAA07AA);

    // constant registers
    ld(4'd12, 8'h55);
    peek(4'd12);
    check("r12_const", Kbus[7:0], 8'h01);
    ld(4'd13, 8'h77);
    peek(4'd13);
    check("r13_const", Kbus[7:0], 8'h00);
    check("mov0_cc", cc, 4'b0100);

    // reset discards a pending write
    @(negedge clk);
    n = 4'd8; Rbus = 4'd9; mData = 8'h99; outEnable = 1'b0;
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("rst_hold_kbus", Kbus, 24'h0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    strobe();
    check("post_rst_wr", Kbus, 24'h990000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dpu_core.md
DPU_CORE -- requirements
Module: dpu_core

Interface
REQ-001 SHALL provide port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL provide port: rst_n  input  1  reset, asynchronous assert, active-low.
REQ-003 SHALL provide port: Abus  input  4  source-A register index.
REQ-004 SHALL provide port: Bbus  input  4  source-B register index.
REQ-005 SHALL provide port: Rbus  input  4  destination register index.
REQ-006 SHALL provide port: n  input  4  operation code.
REQ-007 SHALL provide port: mData  input  8  immediate load data.
REQ-008 SHALL provide port: outEnable  input  1  pixel output strobe.
REQ-009 SHALL provide port: cc  output  4  condition codes {N,Z,C,V} (cc[3]=N … cc[0]=V), registered.
REQ-010 SHALL provide port: Kbus  output  24  pixel word {R9,R10,R11} (X[23:16], Y[15:8], colour[7:0]), registered.
REQ-011 SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-012 Register file: 16 x 8-bit, R0–R15; map R0 Dx, R1 Dy, R2 Error, R3 EInc, R4 EnoInc, R5 Xs, R6 Xe, R7 Ys, R8 Ye, R9 X, R10 Y, R11 colour, R14 scratch, R15 general.
REQ-013 R12 SHALL always read 8'h01 and R13 SHALL always read 8'h00; writes to R12/R13 are ignored.
REQ-014 Reads are combinational from Abus/Bbus; the result is written to R[Rbus] on the rising clk edge (one-cycle latency).
REQ-015 Opcodes: 0 ADD R=A+B; 1 SUB R=A-B; 2 SHL R=A<<1; 3 SHR (arithmetic) R=A>>>1; 4 AND; 5 OR; 6 CMP (A-B, flags only, no register write); 7 MOV R=A; 8 LOAD R=mData; 9–15 NOP (no write, flags held).
REQ-016 Arithmetic is 8-bit two's complement and wraps modulo 256 (e.g. 8'hFF+1 = 8'h00).
REQ-017 Opcodes 0–7 SHALL update cc on the same edge: N=result[7]; Z=(result==0); C=carry out (ADD), NOT borrow (SUB/CMP), bit shifted out (SHL/SHR), 0 (AND/OR/MOV); V=signed overflow (ADD/SUB/CMP), else 0.
REQ-018 LOAD and NOPs SHALL leave cc unchanged.
REQ-019 Kbus SHALL load {R9,R10,R11} on a rising edge where outEnable=1, reading register values before that edge's write; otherwise it holds.
REQ-020 Simultaneous write to R9–R11 and outEnable: Kbus takes the pre-write values; the new values appear on a later strobe.
REQ-021 Rbus=Abus or Rbus=Bbus SHALL be legal; operands are the pre-edge values.

Reset
REQ-022 rst_n=0 SHALL immediately clear R0–R11, R14, R15, cc (4'b0000) and Kbus (24'h0), independent of clk.
REQ-023 Reset asserted mid-operation SHALL discard the pending write; the first write after deassertion occurs on the first rising edge with rst_n=1.

Configuration
REQ-024 Macro DPU_AUTO_OUT_EN: when defined, Kbus SHALL reload {R9,R10,R11} on every rising edge and outEnable is ignored; when undefined, REQ-019 applies.

Verification
REQ-025 Reset: rst_n=0 mid-cycle -> Kbus=0, cc=0, all writable registers read 0 without a clock edge.
REQ-026 LOAD/ADD: LOAD R9=8'h10, then n=0 A=9 B=12 R=9 -> R9=8'h11, cc=0000; LOAD R9=8'hFF, then ADD with R12 -> R9=8'h00, cc=0110 (Z,C).
REQ-027 SUB/CMP: R8=20, R7=5, n=1 A=8 B=7 R=1 -> R1=15, N=0; R2=8'hF6 (-10), n=6 A=2 B=13 -> cc[3]=1, R14 unchanged.
REQ-028 SHL: R1=8'h0F, n=2 A=1 R=4 -> R4=8'h1E, C=0; R1=8'h80 -> R4=8'h00, cc=0110.
REQ-029 Output: R9=3, R10=7, R11=8'hAA, outEnable=1 for one cycle -> Kbus=24'h0307AA; it holds after outEnable=0 while R9 changes (macro undefined).
REQ-030 Constants: LOAD R12=8'h55 -> R12 still reads 8'h01; write to R13 -> still 8'h00.
